// File: rtl/seq_divider.sv
// Iterative signed restoring divider: one quotient bit per clock, then a sign fix-up cycle.
// Quotient truncates toward zero; the remainder takes the sign of the dividend.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             exception,
    output logic             result_rdy,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] qmag_q, qmag_d;
    logic [WIDTH-1:0] dmag_q, dmag_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             exc_q, exc_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            prem_q     <= '0;
            qmag_q     <= '0;
            dmag_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            exc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            prem_q     <= prem_d;
            qmag_q     <= qmag_d;
            dmag_q     <= dmag_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            exc_q      <= exc_d;
        end
    end

    // The partial remainder is always below the divisor magnitude, so WIDTH bits
    // hold it; only the shifted trial value needs the extra top bit.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        prem_d     = prem_q;
        qmag_d     = qmag_q;
        dmag_d     = dmag_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        exc_d      = exc_q;
        shifted    = {prem_q, qmag_q[WIDTH-1]};
        trial      = shifted - {1'b0, dmag_q};

        case (state_q)
            IDLE: begin
                if (ctrl_div) begin
                    qmag_d     = dividend[WIDTH-1] ? -dividend : dividend;
                    dmag_d     = divisor[WIDTH-1] ? -divisor : divisor;
                    neg_quot_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    neg_rem_d  = dividend[WIDTH-1];
                    prem_d     = '0;
                    count_d    = CW'(WIDTH - 1);
                    if (divisor == '0) begin
                        quot_d  = '0;
                        rem_d   = dividend;
                        exc_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                if (!trial[WIDTH]) begin
                    prem_d = trial[WIDTH-1:0];
                    qmag_d = {qmag_q[WIDTH-2:0], 1'b1};
                end else begin
                    prem_d = shifted[WIDTH-1:0];
                    qmag_d = {qmag_q[WIDTH-2:0], 1'b0};
                end
                if (count_q == '0) begin
                    state_d = FIX;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            FIX: begin
                quot_d  = neg_quot_q ? -qmag_q : qmag_q;
                rem_d   = neg_rem_q ? -prem_q : prem_q;
                exc_d   = 1'b0;
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign quotient   = quot_q;
    assign remainder  = rem_q;
    assign exception  = exc_q;
    assign result_rdy = (state_q == DONE);
    assign busy       = (state_q == ITER) || (state_q == FIX);

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results are queued at start and
// compared when result_rdy pulses; latency and busy length are checked per operation.
module tb_seq_divider;

    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             e;
    } exp_t;

    logic             clock;
    logic             reset_n;
    logic             ctrl_div;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             exception;
    logic             result_rdy;
    logic             busy;

    exp_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;
    int   rdyCount   = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ctrl_div   (ctrl_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .exception  (exception),
        .result_rdy (result_rdy),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checkCount++;
        if (obs === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference results come from 64-bit signed arithmetic, which truncates toward zero.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit track);
        exp_t   e;
        longint sa;
        longint sb;
        if (track) begin
            if (b == '0) begin
                e.q = '0;
                e.r = a;
                e.e = 1'b1;
            end else begin
                sa  = longint'($signed(a));
                sb  = longint'($signed(b));
                e.q = WIDTH'(sa / sb);
                e.r = WIDTH'(sa % sb);
                e.e = 1'b0;
            end
            expQ.push_back(e);
        end
        @(negedge clock);
        ctrl_div = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clock);
        #1;
        ctrl_div = 1'b0;
    endtask

    // Counts edges after the start edge until result_rdy; optionally fires a stray
    // start request partway through that the divider must ignore.
    task automatic waitResult(input int expLat, input int expBusy, input int pulseAt);
        int k       = 0;
        int busyCnt = 0;
        while (!result_rdy && k < 100) begin
            if (busy) busyCnt++;
            @(posedge clock);
            #1;
            k++;
            if (k == pulseAt) begin
                ctrl_div = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd3;
            end else if (k == pulseAt + 1) begin
                ctrl_div = 1'b0;
            end
        end
        ctrl_div = 1'b0;
        checkOutput("latency", WIDTH'(k), WIDTH'(expLat));
        checkOutput("busy_cycles", WIDTH'(busyCnt), WIDTH'(expBusy));
        checkOutput("busy_in_done", {31'd0, busy}, 32'd0);
        @(posedge clock);
        #1;
        checkOutput("rdy_one_cycle", {31'd0, result_rdy}, 32'd0);
    endtask

    task automatic runOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        applyStimulus(a, b, 1'b1);
        waitResult((b == '0) ? 0 : WIDTH + 1, (b == '0) ? 0 : WIDTH + 1, -5);
    endtask

    always @(negedge clock) begin
        if (result_rdy) begin
            exp_t e;
            rdyCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_rdy", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("quotient", quotient, e.q);
                checkOutput("remainder", remainder, e.r);
                checkOutput("exception", {31'd0, exception}, {31'd0, e.e});
            end
        end
    end

    initial begin
        int savedRdy;
        reset_n  = 1'b0;
        ctrl_div = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_quotient", quotient, 32'd0);
        checkOutput("reset_remainder", remainder, 32'd0);
        checkOutput("reset_flags", {29'd0, exception, result_rdy, busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        runOp(32'd100, 32'd7);
        runOp(-32'sd100, 32'd7);
        runOp(32'd100, -32'sd7);
        runOp(-32'sd100, -32'sd7);
        runOp(32'd5, 32'd0);
        runOp(32'h8000_0000, 32'hFFFF_FFFF);
        runOp(32'd7, 32'd100);
        runOp(32'hFFFF_FFFF, 32'd1);
        runOp(32'h8000_0000, 32'd1);
        runOp(32'h7FFF_FFFF, 32'h8000_0000);

        applyStimulus(32'd100, 32'd7, 1'b1);
        waitResult(WIDTH + 1, WIDTH + 1, 10);
        runOp(32'd9, 32'd3);

        for (int i = 0; i < 6; i++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            a = $urandom;
            b = (i < 3) ? WIDTH'($urandom_range(1, 1000)) : $urandom;
            if (b == '0) b = 32'd13;
            if (i[0]) b = -b;
            runOp(a, b);
        end

        savedRdy = rdyCount;
        applyStimulus(32'd100, 32'd7, 1'b0);
        repeat (15) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("abort_quotient", quotient, 32'd0);
        checkOutput("abort_remainder", remainder, 32'd0);
        checkOutput("abort_flags", {29'd0, exception, result_rdy, busy}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (50) @(posedge clock);
        #1;
        checkOutput("abort_no_rdy", WIDTH'(rdyCount), WIDTH'(savedRdy));
        checkOutput("abort_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("scoreboard_empty", WIDTH'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
